// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the fetch PC, issues read requests to the instruction cache and
// presents the returned word with its address to the IF/ID latch.
// Handles stalls, EX-stage redirects (including redirects that arrive
// while a cache miss is outstanding) and a terminal halt.
//
// Ports:
//   CLK          system clock, rising edge
//   nRST         asynchronous active-low reset
//   ihit         cache returns iload for imemaddr this cycle
//   iload        instruction word from the cache
//   imemREN      cache read request
//   imemaddr     cache read address (always pc_reg)
//   stall        IF/ID latch hold
//   redirect_en  branch-mispredict / jump-resolve request
//   redirect_pc  redirect target
//   halt         halt retirement indication
//   pc           address of the instruction on instr
//   instr        fetched instruction (iload passthrough)
//   j_en         predecode: JAL or JALR
//   b_en         predecode: conditional branch
//   fetch_valid  instr/pc valid for the IF/ID latch
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        j_en,
  output logic        b_en,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_pc_reg, pend_pc_next;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= FETCH;
      pc_reg      <= PC_INIT;
      pend_pc_reg <= 32'h0000_0000;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pend_pc_reg <= pend_pc_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pend_pc_next = pend_pc_reg;
    if (halt) begin
      // Halt beats redirect and stall; the PC is frozen where it is.
      state_next = HALTED;
    end else begin
      case (state_reg)
        FETCH: begin
          if (redirect_en) begin
            if (ihit) begin
              pc_next = redirect_pc;
            end else begin
              // The cache is mid-miss on pc_reg: keep the address stable
              // and park the target until the miss completes.
              pend_pc_next = redirect_pc;
              state_next   = DISCARD;
            end
          end else if (ihit && !stall) begin
            pc_next = pc_reg + 32'd4;
          end
        end
        DISCARD: begin
          if (redirect_en) begin
            pend_pc_next = redirect_pc;
          end
          if (ihit) begin
            // The returned word belongs to the wrong path; drop it and
            // jump to the newest redirect target.
            pc_next    = redirect_en ? redirect_pc : pend_pc_reg;
            state_next = FETCH;
          end
        end
        default: begin
          state_next = HALTED;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    imemREN     = (state_reg != HALTED);
    fetch_valid = (state_reg == FETCH) && ihit && !redirect_en && !halt;
  end

  assign imemaddr = pc_reg;
  assign pc       = pc_reg;
  assign instr    = iload;
  assign j_en     = (iload[6:0] == OP_JAL) || (iload[6:0] == OP_JALR);
  assign b_en     = (iload[6:0] == OP_BRANCH);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- bench for fetch_unit.
//
// Directed stimulus. A behavioural model (PC value, pending-redirect flag
// and target, halted flag) predicts the outputs and is compared against the
// DUT on every falling clock edge; literal hand-computed expectations are
// also checked at key points of each scenario.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        j_en;
  logic        b_en;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc          (pc),
    .instr       (instr),
    .j_en        (j_en),
    .b_en        (b_en),
    .fetch_valid (fetch_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic        m_pending;
  logic [31:0] m_target;
  logic        m_halted;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc      <= PC_INIT;
      m_pending <= 1'b0;
      m_target  <= 32'h0;
      m_halted  <= 1'b0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (halt) begin
      m_halted <= 1'b1;
    end else if (m_pending) begin
      if (redirect_en) m_target <= redirect_pc;
      if (ihit) begin
        m_pc      <= redirect_en ? redirect_pc : m_target;
        m_pending <= 1'b0;
      end
    end else if (redirect_en) begin
      if (ihit) m_pc <= redirect_pc;
      else begin
        m_pending <= 1'b1;
        m_target  <= redirect_pc;
      end
    end else if (ihit && !stall) begin
      m_pc <= m_pc + 32'd4;
    end
  end

  // Compare process: every falling edge.
  always @(negedge CLK) begin
    logic [31:0] op;
    op = iload & 32'h0000_007F;
    chk("cyc_imemaddr", imemaddr, m_pc);
    chk("cyc_pc", pc, m_pc);
    chk("cyc_imemREN", {31'b0, imemREN}, {31'b0, !m_halted});
    chk("cyc_fetch_valid", {31'b0, fetch_valid},
        {31'b0, !m_halted && !m_pending && ihit && !redirect_en && !halt});
    chk("cyc_instr", instr, iload);
    chk("cyc_j_en", {31'b0, j_en}, {31'b0, (op == 32'h6F) || (op == 32'h67)});
    chk("cyc_b_en", {31'b0, b_en}, {31'b0, op == 32'h63});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic h, input logic st, input logic re, input logic [31:0] rp);
    ihit        = h;
    stall       = st;
    redirect_en = re;
    redirect_pc = rp;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; iload = 32'h0000_0013; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    settle;
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_imemREN", {31'b0, imemREN}, 32'h1);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    tick; tick;
    nRST = 1'b1;

    // Sequential fetch
    drive(1, 0, 0, 0); settle;
    chk("seq_pc0", pc, 32'h0);
    chk("seq_fv0", {31'b0, fetch_valid}, 32'h1);
    tick; settle; chk("seq_pc4", pc, 32'h4);
    tick; settle; chk("seq_pc8", pc, 32'h8);

    // Stall at 8 for two cycles
    drive(1, 1, 0, 0); settle;
    chk("stall_pc_a", pc, 32'h8);
    chk("stall_fv_a", {31'b0, fetch_valid}, 32'h1);
    tick; settle; chk("stall_pc_b", pc, 32'h8);
    drive(1, 0, 0, 0);
    tick; settle; chk("stall_release_pc", pc, 32'hC);
    tick; settle; chk("seq_pc10", pc, 32'h10);

    // Redirect on hit
    drive(1, 0, 1, 32'h100); settle;
    chk("redir_hit_fv", {31'b0, fetch_valid}, 32'h0);
    tick; drive(1, 0, 0, 0); settle;
    chk("redir_hit_addr", imemaddr, 32'h100);
    chk("redir_hit_fv_next", {31'b0, fetch_valid}, 32'h1);

    // Redirect on hit overrides stall
    drive(1, 1, 1, 32'h20);
    tick; drive(0, 0, 0, 0); settle;
    chk("redir_stall_addr", imemaddr, 32'h20);

    // Redirect on miss
    drive(0, 0, 1, 32'h200); settle;
    chk("redir_miss_fv", {31'b0, fetch_valid}, 32'h0);
    tick; drive(0, 0, 0, 0); settle;
    chk("discard_addr_a", imemaddr, 32'h20);
    tick; drive(1, 0, 0, 0); settle;
    chk("discard_addr_b", imemaddr, 32'h20);
    chk("discard_fv", {31'b0, fetch_valid}, 32'h0);
    tick; settle;
    chk("discard_resume", imemaddr, 32'h200);
    chk("discard_resume_fv", {31'b0, fetch_valid}, 32'h1);

    // Second redirect during DISCARD wins
    drive(0, 0, 1, 32'h280);
    tick; drive(0, 0, 1, 32'h300);
    tick; drive(1, 0, 0, 0); settle;
    chk("discard2_fv", {31'b0, fetch_valid}, 32'h0);
    tick; settle;
    chk("discard2_resume", imemaddr, 32'h300);

    // Predecode (no hit, PC does not move)
    drive(0, 0, 0, 0);
    iload = 32'h0000_006F; settle;
    chk("pd_jal_j", {31'b0, j_en}, 32'h1);
    chk("pd_jal_b", {31'b0, b_en}, 32'h0);
    iload = 32'h0000_0063; settle;
    chk("pd_br_b", {31'b0, b_en}, 32'h1);
    chk("pd_br_j", {31'b0, j_en}, 32'h0);
    iload = 32'h0000_0067; settle;
    chk("pd_jalr_j", {31'b0, j_en}, 32'h1);
    iload = 32'h0000_0013; settle;
    chk("pd_addi_j", {31'b0, j_en}, 32'h0);
    chk("pd_addi_b", {31'b0, b_en}, 32'h0);
    chk("pd_instr", instr, 32'h0000_0013);

    // Reset during DISCARD drops the pending target
    drive(0, 0, 1, 32'h500);
    tick; drive(0, 0, 0, 0);
    nRST = 1'b0; settle;
    chk("rst_discard_addr", imemaddr, PC_INIT);
    tick; nRST = 1'b1;
    drive(1, 0, 0, 0);
    tick; settle;
    chk("rst_discard_seq", imemaddr, 32'h4);

    // Wrap at top of address space
    drive(1, 0, 1, 32'hFFFF_FFFC);
    tick; drive(1, 0, 0, 0); settle;
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    tick; settle;
    chk("wrap_post", pc, 32'h0);

    // Halt beats redirect and stall, and sticks
    drive(1, 1, 1, 32'h700); halt = 1'b1; settle;
    chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
    tick; halt = 1'b0; drive(1, 0, 1, 32'h800); settle;
    chk("halted_ren", {31'b0, imemREN}, 32'h0);
    chk("halted_fv", {31'b0, fetch_valid}, 32'h0);
    chk("halted_pc", pc, 32'h0);
    tick; drive(1, 0, 0, 0); tick; settle;
    chk("halted_ren_later", {31'b0, imemREN}, 32'h0);

    // Reset leaves HALTED
    drive(0, 0, 0, 0);
    nRST = 1'b0; settle;
    chk("rst_halt_addr", imemaddr, PC_INIT);
    chk("rst_halt_ren", {31'b0, imemREN}, 32'h1);
    chk("rst_halt_fv", {31'b0, fetch_valid}, 32'h0);
    tick; nRST = 1'b1; drive(1, 0, 0, 0); settle;
    chk("post_halt_fv", {31'b0, fetch_valid}, 32'h1);
    tick; settle;
    chk("post_halt_pc", pc, 32'h4);

    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, giving the fetch address after reset.
REQ-002 SHALL have CLK, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have nRST, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ihit, input, 1, which is 1 when the instruction cache returns iload for imemaddr this cycle.
REQ-005 SHALL have iload, input, 32, the instruction word returned by the instruction cache.
REQ-006 SHALL have imemREN, output, 1, the instruction cache read request.
REQ-007 SHALL have imemaddr, output, 32, the instruction cache read address.
REQ-008 SHALL have stall, input, 1, which is 1 when the IF/ID latch is held (driven by the same source as Write_IF_ID).
REQ-009 SHALL have redirect_en, input, 1, a branch-mispredict or jump-resolve request from EX.
REQ-010 SHALL have redirect_pc, input, 32, the redirect target address.
REQ-011 SHALL have halt, input, 1, the halt retirement indication.
REQ-012 SHALL have pc, output, 32, the address of the instruction presented on instr.
REQ-013 SHALL have instr, output, 32, the fetched instruction (iload passthrough).
REQ-014 SHALL have j_en, output, 1, predecode flag: JAL or JALR opcode.
REQ-015 SHALL have b_en, output, 1, predecode flag: conditional branch opcode.
REQ-016 SHALL have fetch_valid, output, 1, which is 1 when instr/pc are valid for the IF/ID latch (drives pipeline_ctrl).

Function
REQ-017 SHALL implement states FETCH, DISCARD and HALTED, plus a 32-bit pc_reg and a 32-bit pend_pc.
REQ-018 SHALL drive imemaddr = pc_reg and pc = pc_reg at all times.
REQ-019 SHALL drive imemREN = 1 in FETCH and DISCARD, and 0 in HALTED.
REQ-020 SHALL drive instr = iload combinationally.
REQ-021 SHALL set j_en = 1 iff iload[6:0] is 7'b1101111 or 7'b1100111.
REQ-022 SHALL set b_en = 1 iff iload[6:0] is 7'b1100011.
REQ-023 SHALL assert fetch_valid iff state is FETCH, ihit = 1, redirect_en = 0 and halt = 0.
REQ-024 In FETCH with fetch_valid = 1 and stall = 0, SHALL update pc_reg <= pc_reg + 4 (32-bit modulo; FFFF_FFFC wraps to 0000_0000).
REQ-025 In FETCH with fetch_valid = 1 and stall = 1, SHALL hold pc_reg; the same instruction is re-presented the next cycle.
REQ-026 In FETCH with redirect_en = 1 and ihit = 1, SHALL update pc_reg <= redirect_pc and stay in FETCH; the returned word is dropped. Redirect overrides stall.
REQ-027 In FETCH with redirect_en = 1 and ihit = 0, SHALL latch pend_pc <= redirect_pc, hold pc_reg (imemaddr stays stable until the miss resolves) and go to DISCARD.
REQ-028 In DISCARD, fetch_valid SHALL be 0.
REQ-029 In DISCARD, a new redirect_en SHALL overwrite pend_pc (newest wins).
REQ-030 In DISCARD with ihit = 1, SHALL update pc_reg <= (redirect_en ? redirect_pc : pend_pc) and go to FETCH.
REQ-031 With halt = 1 in any state, SHALL go to HALTED next cycle, with highest priority over redirect and stall.
REQ-032 HALTED SHALL be left only by reset.
REQ-033 Latency: SHALL take 0 cycles from ihit to fetch_valid, and 1 cycle from an accepted redirect (REQ-026) to imemaddr = target.

Reset
REQ-034 On nRST = 0, SHALL immediately set state = FETCH, pc_reg = PC_INIT and pend_pc = 0, giving imemaddr = PC_INIT, imemREN = 1 and fetch_valid = 0 (while ihit = 0).
REQ-035 Reset asserted mid-DISCARD or in HALTED SHALL discard pend_pc and resume fetching at PC_INIT.

Verification
REQ-036 Sequential fetch: ihit = 1 held, stall = 0 for 3 cycles from reset -> pc = 0, 4, 8 and fetch_valid = 1 in each cycle.
REQ-037 Stall: ihit = 1, stall = 1 at pc = 8 for 2 cycles -> pc stays 8 and fetch_valid = 1; releasing stall -> pc = 0xC.
REQ-038 Redirect on hit: redirect_en = 1, redirect_pc = 0x100, ihit = 1 at pc = 0x10 -> fetch_valid = 0 that cycle; next cycle imemaddr = 0x100.
REQ-039 Redirect on miss: redirect_pc = 0x200, ihit = 0 at pc = 0x20 -> state DISCARD, imemaddr = 0x20; ihit = 1 two cycles later with fetch_valid = 0 -> next imemaddr = 0x200. A second redirect to 0x300 during DISCARD -> resumes at 0x300.
REQ-040 Predecode: iload = 0x0000006F -> j_en = 1, b_en = 0; iload = 0x00000063 -> b_en = 1, j_en = 0; iload = 0x00000013 -> both 0.
REQ-041 Halt/wrap: pc_reg = 0xFFFFFFFC with a hit -> next pc = 0; halt = 1 -> imemREN = 0 and fetch_valid = 0 until nRST pulse, then imemaddr = PC_INIT.
